// File: rtl/dds_hop_seq.sv
// dds_hop_seq: multi-lane DDS phase sequencer (fixed/hop/tri-sweep FCW, PRT gate); clk_user_bufg/rst_glb in, cfg_* shadow-latched on cfg_load, phase_o/fcw_o/gate_o/hop_o/valid_o registered out
module dds_hop_seq #(
  parameter int PAR = 16,
  parameter int PW  = 32,
  parameter int CW  = 32
) (
  input  logic              clk_user_bufg,
  input  logic              rst_glb,
  input  logic              cfg_load,
  input  logic [1:0]        cfg_mode,
  input  logic [PW-1:0]     cfg_fcw_start,
  input  logic [PW-1:0]     cfg_fcw_stop,
  input  logic [PW-1:0]     cfg_fcw_step,
  input  logic [CW-1:0]     cfg_dwell,
  input  logic              cfg_pulse_en,
  input  logic [CW-1:0]     cfg_prt_width,
  input  logic [CW-1:0]     cfg_prt_cycle,
  output logic [PAR*PW-1:0] phase_o,
  output logic [PW-1:0]     fcw_o,
  output logic              gate_o,
  output logic              hop_o,
  output logic              valid_o
);
  localparam logic [1:0] M_HOP = 2'd1;
  localparam logic [1:0] M_TRI = 2'd2;
  logic [1:0] mode_s;
  logic [PW-1:0] start_s, stop_s, step_s, acc, fcw, fcw_nx;
  logic [CW-1:0] dwell_s, width_s, cycle_s, dwell_cnt, prt_cnt;
  logic pen_s, dir, dir_nx, run, hop, hopping, dwell_term, prt_term, gate_s;
  logic [PW:0] up_sum, lo_sum;
  logic [PAR*PW-1:0] phase_n;
  assign hopping = mode_s == M_HOP || mode_s == M_TRI;
  assign dwell_term = dwell_cnt >= (dwell_s == '0 ? CW'(1) : dwell_s) - CW'(1);
  assign prt_term = cycle_s == '0 || prt_cnt >= cycle_s - CW'(1);
  assign gate_s = !pen_s || cycle_s == '0 || prt_cnt < width_s;
  assign up_sum = {1'b0, fcw} + {1'b0, step_s};
  assign lo_sum = {1'b0, start_s} + {1'b0, step_s};
  always_comb begin
    fcw_nx = fcw;
    dir_nx = dir;
    if (stop_s <= start_s) fcw_nx = start_s;
    else if (mode_s == M_HOP) fcw_nx = up_sum > {1'b0, stop_s} ? start_s : up_sum[PW-1:0];
    else if (!dir) begin
      dir_nx = up_sum > {1'b0, stop_s};
      fcw_nx = !dir_nx ? up_sum[PW-1:0] : {1'b0, fcw} < lo_sum ? start_s : fcw - step_s;
    end else begin
      dir_nx = !({1'b0, fcw} < lo_sum);
      fcw_nx = dir_nx ? fcw - step_s : up_sum > {1'b0, stop_s} ? stop_s : up_sum[PW-1:0];
    end
  end
  always_comb begin
    phase_n = '0;
    for (int k = 0; k < PAR; k++) phase_n[k*PW +: PW] = acc + PW'(k) * fcw;
  end
  always_ff @(posedge clk_user_bufg or negedge rst_glb) begin
    if (!rst_glb) begin
      mode_s <= '0;
      start_s <= '0;
      stop_s <= '0;
      step_s <= '0;
      dwell_s <= '0;
      pen_s <= 1'b0;
      width_s <= '0;
      cycle_s <= '0;
      acc <= '0;
      fcw <= '0;
      dir <= 1'b0;
      dwell_cnt <= '0;
      prt_cnt <= '0;
      run <= 1'b0;
      hop <= 1'b0;
    end else if (cfg_load) begin
      mode_s <= cfg_mode;
      start_s <= cfg_fcw_start;
      stop_s <= cfg_fcw_stop;
      step_s <= cfg_fcw_step;
      dwell_s <= cfg_dwell;
      pen_s <= cfg_pulse_en;
      width_s <= cfg_prt_width;
      cycle_s <= cfg_prt_cycle;
      acc <= '0;
      fcw <= cfg_fcw_start;
      dir <= 1'b0;
      dwell_cnt <= '0;
      prt_cnt <= '0;
      run <= 1'b1;
      hop <= 1'b0;
    end else if (run) begin
      acc <= acc + PW'(PAR) * fcw;
      dwell_cnt <= dwell_term ? '0 : dwell_cnt + CW'(1);
      prt_cnt <= prt_term ? '0 : prt_cnt + CW'(1);
      fcw <= dwell_term && hopping ? fcw_nx : fcw;
      dir <= dwell_term && hopping ? dir_nx : dir;
      hop <= dwell_term && hopping;
    end
  end
  always_ff @(posedge clk_user_bufg or negedge rst_glb) begin
    if (!rst_glb) begin
      phase_o <= '0;
      fcw_o <= '0;
      gate_o <= 1'b0;
      hop_o <= 1'b0;
      valid_o <= 1'b0;
    end else begin
      phase_o <= phase_n;
      fcw_o <= fcw;
      gate_o <= run && gate_s;
      hop_o <= hop;
      valid_o <= run;
    end
  end
endmodule

// File: tb/tb_dds_hop_seq.sv
// tb_dds_hop_seq: directed and randomized check of dds_hop_seq against a word-indexed reference model
module tb_dds_hop_seq;
  localparam int PAR = 16;
  localparam int PW = 32;
  localparam int CW = 32;
  localparam longint MASK = 64'hffff_ffff;
  logic clk = 1'b0;
  logic rst_glb;
  logic cfg_load;
  logic [1:0] cfg_mode;
  logic [PW-1:0] cfg_fcw_start, cfg_fcw_stop, cfg_fcw_step;
  logic [CW-1:0] cfg_dwell, cfg_prt_width, cfg_prt_cycle;
  logic cfg_pulse_en;
  logic [PAR*PW-1:0] phase_o;
  logic [PW-1:0] fcw_o;
  logic gate_o, hop_o, valid_o;
  int n_chk = 0;
  int n_fail = 0;
  bit live = 0;
  dds_hop_seq #(.PAR(PAR), .PW(PW), .CW(CW)) dut (
    .clk_user_bufg(clk),
    .rst_glb(rst_glb),
    .cfg_load(cfg_load),
    .cfg_mode(cfg_mode),
    .cfg_fcw_start(cfg_fcw_start),
    .cfg_fcw_stop(cfg_fcw_stop),
    .cfg_fcw_step(cfg_fcw_step),
    .cfg_dwell(cfg_dwell),
    .cfg_pulse_en(cfg_pulse_en),
    .cfg_prt_width(cfg_prt_width),
    .cfg_prt_cycle(cfg_prt_cycle),
    .phase_o(phase_o),
    .fcw_o(fcw_o),
    .gate_o(gate_o),
    .hop_o(hop_o),
    .valid_o(valid_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic run_cfg(input int mode, input longint st, input longint sp, input longint stp,
                         input int dwl, input bit pen, input int wd, input int cy, input int nw);
    longint f, ph;
    int dw;
    bit up, h;
    @(negedge clk);
    cfg_mode = 2'(mode);
    cfg_fcw_start = PW'(st);
    cfg_fcw_stop = PW'(sp);
    cfg_fcw_step = PW'(stp);
    cfg_dwell = CW'(dwl);
    cfg_pulse_en = pen;
    cfg_prt_width = CW'(wd);
    cfg_prt_cycle = CW'(cy);
    cfg_load = 1'b1;
    @(negedge clk);
    cfg_load = 1'b0;
    chk("valid_gap", 64'(valid_o), 64'(live));
    @(negedge clk);
    live = 1;
    f = st;
    ph = 0;
    up = 1;
    dw = dwl == 0 ? 1 : dwl;
    for (int n = 0; n < nw; n++) begin
      h = 0;
      if (n > 0 && n % dw == 0 && (mode == 1 || mode == 2)) begin
        h = 1;
        if (sp <= st) f = st;
        else if (mode == 1) f = f + stp > sp ? st : f + stp;
        else if (up) begin
          if (f + stp > sp) begin
            up = 0;
            f = f - stp < st ? st : f - stp;
          end else f = f + stp;
        end else begin
          if (f - stp < st) begin
            up = 1;
            f = f + stp > sp ? sp : f + stp;
          end else f = f - stp;
        end
      end
      chk("valid", 64'(valid_o), 64'd1);
      chk("fcw", 64'(fcw_o), 64'(f));
      chk("hop", 64'(hop_o), 64'(h));
      chk("gate", 64'(gate_o), 64'(!pen || cy == 0 || (n % cy) < wd));
      for (int k = 0; k < PAR; k++)
        chk($sformatf("lane%0d", k), 64'(phase_o[k*PW +: PW]), (ph + k * f) & MASK);
      ph = (ph + PAR * f) & MASK;
      @(negedge clk);
    end
  endtask
  initial begin
    longint st, stp, sp;
    rst_glb = 1'b0;
    cfg_load = 1'b0;
    cfg_mode = '0;
    cfg_fcw_start = '0;
    cfg_fcw_stop = '0;
    cfg_fcw_step = '0;
    cfg_dwell = '0;
    cfg_pulse_en = 1'b0;
    cfg_prt_width = '0;
    cfg_prt_cycle = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_gate", 64'(gate_o), 64'd0);
    chk("rst_phase", 64'(|phase_o), 64'd0);
    rst_glb = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_valid", 64'(valid_o), 64'd0);
    chk("idle_gate", 64'(gate_o), 64'd0);
    run_cfg(0, 64'h0100_0000, 0, 0, 1, 0, 0, 0, 34);
    run_cfg(1, 100, 200, 50, 4, 0, 0, 0, 20);
    run_cfg(2, 100, 200, 50, 2, 0, 0, 0, 14);
    run_cfg(2, 100, 50, 50, 2, 0, 0, 0, 10);
    run_cfg(1, 64'hF000_0000, 64'hFFFF_FFFF, 64'h1000_0000, 1, 0, 0, 0, 6);
    run_cfg(2, 64'hE000_0000, 64'hFFFF_FFFF, 64'h1000_0000, 1, 0, 0, 0, 8);
    run_cfg(2, 100, 200, 0, 1, 0, 0, 0, 5);
    run_cfg(0, 7, 0, 0, 0, 1, 3, 8, 24);
    run_cfg(0, 7, 0, 0, 3, 1, 8, 8, 10);
    run_cfg(0, 7, 0, 0, 3, 1, 0, 8, 10);
    run_cfg(0, 7, 0, 0, 3, 1, 5, 0, 10);
    run_cfg(2, 100, 200, 50, 2, 1, 2, 5, 7);
    run_cfg(2, 300, 500, 70, 2, 1, 1, 3, 12);
    run_cfg(3, 1234, 9999, 77, 2, 0, 0, 0, 6);
    @(negedge clk);
    #2 rst_glb = 1'b0;
    #1;
    chk("arst_valid", 64'(valid_o), 64'd0);
    chk("arst_gate", 64'(gate_o), 64'd0);
    chk("arst_fcw", 64'(fcw_o), 64'd0);
    chk("arst_phase", 64'(|phase_o), 64'd0);
    chk("arst_hop", 64'(hop_o), 64'd0);
    @(negedge clk);
    rst_glb = 1'b1;
    live = 0;
    repeat (4) @(negedge clk);
    chk("post_rst_valid", 64'(valid_o), 64'd0);
    for (int t = 0; t < 30; t++) begin
      st = longint'($urandom_range(0, 32'h3FFF_FFFF));
      stp = longint'($urandom_range(0, 32'h07FF_FFFF));
      sp = $urandom_range(0, 5) == 0 ? longint'($urandom_range(0, 32'h3FFF_FFFF))
                                     : st + stp * $urandom_range(0, 5) + longint'($urandom_range(0, 32'h07FF_FFFF));
      run_cfg(int'($urandom_range(0, 3)), st, sp, stp, int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 9)), int'($urandom_range(0, 9)), int'($urandom_range(4, 30)));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
